// File: rtl/vid_proc_pipe.sv
// vid_proc_pipe: fixed-latency video pixel processor (pass / gray / binary / invert).
// Latency is 3 + PIPE_EXTRA cycles, the same in every mode.
// The mode and threshold are latched at each frame start (vsync rising edge).
// Optional build macro VID_PROC_FRAME_CNT_EN enables the frame_cnt counter.
// Without the macro, frame_cnt is tied to 0.
module vid_proc_pipe #(
    parameter int DATA_W     = 8,
    parameter int PIPE_EXTRA = 0
) (
    input  logic              hdmi_clk,
    input  logic              rst_n,
    input  logic              in_de,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] thresh_i,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    output logic [15:0]       frame_cnt
);
    localparam int                BUS_W      = 3 + 3 * DATA_W;
    localparam int                PROD_W     = DATA_W + 8;
    localparam logic [DATA_W-1:0] PIX_MAX    = '1;
    localparam logic [DATA_W-1:0] THRESH_RST = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [PROD_W-1:0] W_R        = PROD_W'(77);
    localparam logic [PROD_W-1:0] W_G        = PROD_W'(150);
    localparam logic [PROD_W-1:0] W_B        = PROD_W'(29);

    // Frame-start detection and active control registers
    logic              vs_prev_reg;
    logic              armed_reg;
    logic [1:0]        mode_act_reg;
    logic [DATA_W-1:0] thresh_act_reg;
    logic              frame_start;
    logic [1:0]        mode_sel;
    logic [DATA_W-1:0] thresh_sel;

    // armed_reg suppresses detection in the first cycle after reset.
    // This holds even when vsync is already high in that cycle.
    assign frame_start = armed_reg & in_vs & ~vs_prev_reg;
    // The frame-start pixel must already see the newly requested controls.
    assign mode_sel    = frame_start ? mode_i   : mode_act_reg;
    assign thresh_sel  = frame_start ? thresh_i : thresh_act_reg;

    // Track previous vsync and latch the controls at each frame start
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            vs_prev_reg    <= 1'b0;
            armed_reg      <= 1'b0;
            mode_act_reg   <= 2'd0;
            thresh_act_reg <= THRESH_RST;
        end else begin
            vs_prev_reg <= in_vs;
            armed_reg   <= 1'b1;
            if (frame_start) begin
                mode_act_reg   <= mode_i;
                thresh_act_reg <= thresh_i;
            end
        end
    end

    // Stage 1 registers: input capture.
    // Mode and threshold travel with each pixel.
    logic              s1_de_reg, s1_hs_reg, s1_vs_reg;
    logic [DATA_W-1:0] s1_r_reg, s1_g_reg, s1_b_reg;
    logic [1:0]        s1_mode_reg;
    logic [DATA_W-1:0] s1_thresh_reg;

    // Stage 1: register inputs together with the controls that apply to them
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            s1_de_reg     <= 1'b0;
            s1_hs_reg     <= 1'b0;
            s1_vs_reg     <= 1'b0;
            s1_r_reg      <= '0;
            s1_g_reg      <= '0;
            s1_b_reg      <= '0;
            s1_mode_reg   <= 2'd0;
            s1_thresh_reg <= '0;
        end else begin
            s1_de_reg     <= in_de;
            s1_hs_reg     <= in_hs;
            s1_vs_reg     <= in_vs;
            s1_r_reg      <= in_r;
            s1_g_reg      <= in_g;
            s1_b_reg      <= in_b;
            s1_mode_reg   <= mode_sel;
            s1_thresh_reg <= thresh_sel;
        end
    end

    // Stage 2 registers: weighted luma products plus the raw pixel
    logic              s2_de_reg, s2_hs_reg, s2_vs_reg;
    logic [DATA_W-1:0] s2_r_reg, s2_g_reg, s2_b_reg;
    logic [PROD_W-1:0] s2_pr_reg, s2_pg_reg, s2_pb_reg;
    logic [1:0]        s2_mode_reg;
    logic [DATA_W-1:0] s2_thresh_reg;

    // Stage 2: compute the weighted products.
    // The weights sum to 256, so the total never overflows PROD_W.
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            s2_de_reg     <= 1'b0;
            s2_hs_reg     <= 1'b0;
            s2_vs_reg     <= 1'b0;
            s2_r_reg      <= '0;
            s2_g_reg      <= '0;
            s2_b_reg      <= '0;
            s2_pr_reg     <= '0;
            s2_pg_reg     <= '0;
            s2_pb_reg     <= '0;
            s2_mode_reg   <= 2'd0;
            s2_thresh_reg <= '0;
        end else begin
            s2_de_reg     <= s1_de_reg;
            s2_hs_reg     <= s1_hs_reg;
            s2_vs_reg     <= s1_vs_reg;
            s2_r_reg      <= s1_r_reg;
            s2_g_reg      <= s1_g_reg;
            s2_b_reg      <= s1_b_reg;
            s2_pr_reg     <= {8'd0, s1_r_reg} * W_R;
            s2_pg_reg     <= {8'd0, s1_g_reg} * W_G;
            s2_pb_reg     <= {8'd0, s1_b_reg} * W_B;
            s2_mode_reg   <= s1_mode_reg;
            s2_thresh_reg <= s1_thresh_reg;
        end
    end

    // Stage 3 combinational logic: sum, shift, mode select and blanking
    logic [DATA_W-1:0] y_val;
    logic [DATA_W-1:0] pix_r, pix_g, pix_b;
    logic [BUS_W-1:0]  core_next;

    // Select the output pixel for the pixel's mode.
    // Blank all channels when data-enable is low.
    always_comb begin
        y_val = DATA_W'((s2_pr_reg + s2_pg_reg + s2_pb_reg) >> 8);
        pix_r = s2_r_reg;
        pix_g = s2_g_reg;
        pix_b = s2_b_reg;
        case (s2_mode_reg)
            2'd1: begin
                pix_r = y_val;
                pix_g = y_val;
                pix_b = y_val;
            end
            2'd2: begin
                pix_r = (y_val > s2_thresh_reg) ? PIX_MAX : '0;
                pix_g = (y_val > s2_thresh_reg) ? PIX_MAX : '0;
                pix_b = (y_val > s2_thresh_reg) ? PIX_MAX : '0;
            end
            2'd3: begin
                pix_r = PIX_MAX - s2_r_reg;
                pix_g = PIX_MAX - s2_g_reg;
                pix_b = PIX_MAX - s2_b_reg;
            end
            default: ;
        endcase
        if (!s2_de_reg) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
        core_next = {s2_de_reg, s2_hs_reg, s2_vs_reg, pix_r, pix_g, pix_b};
    end

    // Stage 3 and the extra delay stages.
    // pipe_reg[0] is the core output; the last entry drives the ports.
    logic [PIPE_EXTRA:0][BUS_W-1:0] pipe_reg;

    // Stage 3 register followed by PIPE_EXTRA plain delay stages
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= core_next;
            for (int i = 1; i <= PIPE_EXTRA; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign {out_de, out_hs, out_vs, out_r, out_g, out_b} = pipe_reg[PIPE_EXTRA];

`ifdef VID_PROC_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    // Count frame starts; the counter wraps naturally at 16 bits
    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= 16'd0;
        end else if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vid_proc_pipe.sv
// tb_vid_proc_pipe: directed and random frames driven into two instances
// (PIPE_EXTRA = 0 and PIPE_EXTRA = 2).
// Every cycle, both instances are compared against a frame-level reference model.
// Literal checks pin the model to hand-computed pixels.
module tb_vid_proc_pipe;
    logic       hdmi_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [1:0] mode_i   = 2'd1;
    logic [7:0] thresh_i = 8'd0;

    logic       d0_de, d0_hs, d0_vs, d1_de, d1_hs, d1_vs;
    logic [7:0] d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;
    logic [15:0] d0_cnt, d1_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 hdmi_clk = ~hdmi_clk;

    vid_proc_pipe #(.DATA_W(8), .PIPE_EXTRA(0)) u_dut0 (
        .hdmi_clk(hdmi_clk), .rst_n(rst_n),
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .mode_i(mode_i), .thresh_i(thresh_i),
        .out_de(d0_de), .out_hs(d0_hs), .out_vs(d0_vs),
        .out_r(d0_r), .out_g(d0_g), .out_b(d0_b),
        .frame_cnt(d0_cnt)
    );

    vid_proc_pipe #(.DATA_W(8), .PIPE_EXTRA(2)) u_dut1 (
        .hdmi_clk(hdmi_clk), .rst_n(rst_n),
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .mode_i(mode_i), .thresh_i(thresh_i),
        .out_de(d1_de), .out_hs(d1_hs), .out_vs(d1_vs),
        .out_r(d1_r), .out_g(d1_g), .out_b(d1_b),
        .frame_cnt(d1_cnt)
    );

    logic [26:0] d0_bus, d1_bus;
    assign d0_bus = {d0_de, d0_hs, d0_vs, d0_r, d0_g, d0_b};
    assign d1_bus = {d1_de, d1_hs, d1_vs, d1_r, d1_g, d1_b};

    // The counter is only present when VID_PROC_FRAME_CNT_EN is defined.
    function automatic logic [15:0] exp_cnt(input int n);
`ifdef VID_PROC_FRAME_CNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // Pixel rule applied from the mode definitions, using plain integer arithmetic.
    function automatic logic [23:0] proc_pix(input logic de, input logic [1:0] md,
                                             input logic [7:0] th, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b);
        int y;
        y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256;
        if (!de) return 24'd0;
        case (md)
            2'd0: return {r, g, b};
            2'd1: return {8'(y), 8'(y), 8'(y)};
            2'd2: return (y > int'(th)) ? 24'hFFFFFF : 24'd0;
            default: return {8'(255 - int'(r)), 8'(255 - int'(g)), 8'(255 - int'(b))};
        endcase
    endfunction

    // Reference model state: one history entry per clock edge
    logic [26:0] hist [0:8191];
    int          edge_cnt = 0;
    int          last_rst = -1000;
    logic [1:0]  mode_m;
    logic [7:0]  th_m;
    logic        vsp_m, armed_m, fs_m;
    int          cnt_m;

    // Model update at each edge, following the frame-start and latch rules
    always @(posedge hdmi_clk) begin
        if (!rst_n) begin
            mode_m = 2'd0; th_m = 8'd128; vsp_m = 1'b0; armed_m = 1'b0; cnt_m = 0;
            last_rst = edge_cnt;
            hist[edge_cnt % 8192] = '0;
        end else begin
            fs_m = armed_m && in_vs && !vsp_m;
            if (fs_m) begin
                mode_m = mode_i; th_m = thresh_i; cnt_m = (cnt_m + 1) % 65536;
            end
            hist[edge_cnt % 8192] = {in_de, in_hs, in_vs,
                                     proc_pix(in_de, mode_m, th_m, in_r, in_g, in_b)};
            vsp_m = in_vs; armed_m = 1'b1;
        end
        edge_cnt++;
    end

    function automatic logic [26:0] model_out(input int lat, input int m);
        if (m - last_rst < lat) return '0;
        return hist[(m - lat + 1) % 8192];
    endfunction

    task automatic cmp(input string name, input logic [26:0] got, input logic [26:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h want %h", name, edge_cnt, got, want);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge hdmi_clk) begin
        if (edge_cnt > 0) begin
            cmp("model_l3", d0_bus, model_out(3, edge_cnt - 1));
            cmp("model_l5", d1_bus, model_out(5, edge_cnt - 1));
            cmp("cnt_l3", {11'd0, d0_cnt}, {11'd0, exp_cnt(cnt_m)});
            cmp("cnt_l5", {11'd0, d1_cnt}, {11'd0, exp_cnt(cnt_m)});
        end
    end

    task automatic lit(input string name, input logic [26:0] got, input logic [26:0] want);
        cmp(name, got, want);
        $display("check %-16s got %h want %h", name, got, want);
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_de = de; in_hs = hs; in_vs = vs; in_r = r; in_g = g; in_b = b;
        @(posedge hdmi_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    initial begin
        #1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        lit("reset_out_l3", d0_bus, 27'd0);
        lit("reset_out_l5", d1_bus, 27'd0);
        lit("reset_cnt", {11'd0, d0_cnt}, 27'd0);

        // vsync already high on reset release: no frame start, mode stays 0
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        lit("no_fs_at_release", {11'd0, d0_cnt}, 27'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd20, 8'd30);
        idle(2);
        lit("pass_10_20_30", d0_bus, {3'b100, 8'd10, 8'd20, 8'd30});

        // Gray frame
        mode_i = 2'd1;
        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 8'd50);
        idle(2);
        lit("gray_124", d0_bus, {3'b100, 8'd124, 8'd124, 8'd124});
        lit("cnt_1", {11'd0, d0_cnt}, {11'd0, exp_cnt(1)});

        // Binary frame, threshold 100
        mode_i = 2'd2; thresh_i = 8'd100;
        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 8'd50);
        drive(1'b1, 1'b0, 1'b0, 8'd50, 8'd50, 8'd50);
        idle(1);
        lit("bin_high", d0_bus, {3'b100, 8'd255, 8'd255, 8'd255});
        idle(1);
        lit("bin_low", d0_bus, {3'b100, 8'd0, 8'd0, 8'd0});

        // Invert frame; a mid-frame mode change is ignored
        mode_i = 2'd3;
        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 8'd50);
        mode_i = 2'd0;
        drive(1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 8'd50);
        idle(1);
        lit("invert", d0_bus, {3'b100, 8'd55, 8'd155, 8'd205});
        idle(1);
        lit("invert_held", d0_bus, {3'b100, 8'd55, 8'd155, 8'd205});
        drive(1'b0, 1'b1, 1'b0, 8'd99, 8'd99, 8'd99);
        idle(2);
        lit("blank_de0", d0_bus, {3'b010, 24'd0});
        lit("cnt_3", {11'd0, d1_cnt}, {11'd0, exp_cnt(3)});

        // The pixel in the frame-start cycle already uses the new mode (pass)
        drive(1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        lit("fs_pixel_mode", d0_bus, {3'b101, 8'd1, 8'd2, 8'd3});
        idle(2);
        lit("fs_pixel_l5", d1_bus, {3'b101, 8'd1, 8'd2, 8'd3});

        // Random frames checked against the model
        for (int f = 0; f < 4; f++) begin
            mode_i = 2'($urandom_range(0, 3)); thresh_i = 8'($urandom);
            drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
            drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
            for (int p = 0; p < 32; p++) begin
                if (p == 13) mode_i = 2'($urandom_range(0, 3));
                drive((p % 8) != 7, (p % 8) == 7, 1'b0,
                      8'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        // Reset asserted mid-line
        drive(1'b1, 1'b0, 1'b0, 8'd7, 8'd8, 8'd9);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'd11, 8'd12, 8'd13);
        lit("midrst_l3", d0_bus, 27'd0);
        lit("midrst_l5", d1_bus, 27'd0);
        lit("midrst_cnt", {11'd0, d1_cnt}, 27'd0);
        rst_n = 1'b1;
        mode_i = 2'd3;
        drive(1'b1, 1'b0, 1'b0, 8'd40, 8'd50, 8'd60);
        idle(2);
        lit("rst_mode0", d0_bus, {3'b100, 8'd40, 8'd50, 8'd60});
        for (int p = 0; p < 12; p++) drive(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
